fetch_sequencer: RTL

Controller between the fetch stage and the AES datapath. It accepts one 4096-bit fetched block at a time through a valid/ready handshake and issues it to the AES core as 128-bit words, most-significant word first. It can drop the leading all-zero words that fetch uses to pad short blocks, and it reports end-of-stream when the last block of a stream has been fully issued.

---
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-to-AES sequencer: buffers one fetched block and issues it MSW-first as AES words,
// optionally dropping leading all-zero padding words.
module fetch_sequencer #(
   parameter int unsigned BLK_W  = 4096,
   parameter int unsigned WORD_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BLK_W-1:0]  blk_data,
   input  logic              blk_valid,
   input  logic              blk_last,
   input  logic              skip_zero,
   output logic              blk_ready,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   output logic              word_first,
   output logic              word_last,
   input  logic              word_ready,
   output logic              busy,
   output logic              stream_done,
   output logic [15:0]       blk_count
);

   localparam int unsigned NUM_WORDS = BLK_W / WORD_W;
   localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_WORDS - 1);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StIssue = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [BLK_W-1:0]  buf_q, buf_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              last_q, last_d;
   logic              skip_q, skip_d;
   logic              first_sent_q, first_sent_d;
   logic              done_q, done_d;
   logic [15:0]       count_q, count_d;

   logic [WORD_W-1:0] cur_word;
   logic              in_issue;
   logic              skipping;

   assign cur_word = buf_q[idx_q*WORD_W +: WORD_W];
   assign in_issue = (state_q == StIssue);
   // Only leading zero words are dropped; skip_q clears on the first non-zero word.
   assign skipping = in_issue && skip_q && (cur_word == '0);

   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      idx_d        = idx_q;
      last_d       = last_q;
      skip_d       = skip_q;
      first_sent_d = first_sent_q;
      done_d       = done_q;
      count_d      = count_q;
      case (state_q)
         StIdle: begin
            if (blk_valid) begin
               buf_d        = blk_data;
               last_d       = blk_last;
               skip_d       = skip_zero;
               idx_d        = IDX_MAX;
               first_sent_d = 1'b0;
               count_d      = count_q + 16'd1;
               done_d       = 1'b0;
               state_d      = StIssue;
            end
         end
         StIssue: begin
            if (skipping) begin
               if (idx_q == '0) begin
                  state_d = StIdle;
                  if (last_q) done_d = 1'b1;
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end else begin
               skip_d = 1'b0;
               if (word_ready) begin
                  first_sent_d = 1'b1;
                  if (idx_q == '0) begin
                     state_d = StIdle;
                     if (last_q) done_d = 1'b1;
                  end else begin
                     idx_d = idx_q - 1'b1;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         buf_q        <= '0;
         idx_q        <= IDX_MAX;
         last_q       <= 1'b0;
         skip_q       <= 1'b0;
         first_sent_q <= 1'b0;
         done_q       <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         idx_q        <= idx_d;
         last_q       <= last_d;
         skip_q       <= skip_d;
         first_sent_q <= first_sent_d;
         done_q       <= done_d;
         count_q      <= count_d;
      end
   end

   assign blk_ready   = !in_issue;
   assign busy        = in_issue;
   assign word_data   = cur_word;
   assign word_valid  = in_issue && !skipping;
   assign word_first  = in_issue && !first_sent_q;
   assign word_last   = in_issue && (idx_q == '0);
   assign stream_done = done_q;
   assign blk_count   = count_q;

endmodule
